weight_bank: RTL and testbench

Parametrised successor to the per-layer weight store of the training datapath. It holds `layer_size × row_count` rows of `size` signed weights. It serves one row read, one row write and one gradient-descent row update per clock. Compared with the earlier store, it adds a shift-scaled learning rate, saturating arithmetic, defined collision priority, range checking with a sticky error flag, a read-valid strobe, and a hardware clear sweep after reset. It sits between the forward-pass row fetcher and the backprop `dc_dw` producer.

---
 rtl/weight_bank_pkg.sv | 40 ++++
 rtl/weight_bank_clear_fsm.sv | 55 +++++
 rtl/weight_bank.sv | 123 ++++++++++++
 tb/tb_weight_bank.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_bank_pkg.sv
// Shared types and arithmetic helpers for the gradient-descent weight bank.
// Holds the two-state encoding and the saturating subtract used by row updates.
package gdo;

  localparam logic st_clear = 1'b0;
  localparam logic st_ready = 1'b1;

  typedef enum logic {
    STATE_CLEAR = st_clear,
    STATE_READY = st_ready
  } state_t;

  function automatic logic signed [63:0] gdo_sub(input logic signed [63:0] a,
                                                 input logic signed [63:0] b);
    return a - b;
  endfunction

  // Operands arrive sign-extended to 64 bits, so the difference never wraps
  // for weights up to 32 bits; only the clamp to data_size bits matters.
  function automatic logic signed [63:0] gdo_sat_sub(input logic signed [63:0] a,
                                                     input logic signed [63:0] b,
                                                     input int data_size);
    logic signed [63:0] diff;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] result;
    diff = gdo_sub(a, b);
    hi   = (64'sd1 <<< (data_size - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (data_size - 1));
    if (diff > hi) begin
      result = hi;
    end else if (diff < lo) begin
      result = lo;
    end else begin
      result = diff;
    end
    return result;
  endfunction

endpackage

// File: rtl/weight_bank_clear_fsm.sv
// Clear-sweep controller: after reset or a clear request it walks every flat
// row address once, then raises ready until the next clear.
module weight_bank_clear_fsm
  import gdo::*;
#(
  parameter int depth  = 15,
  parameter int addr_w = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              ready,
  output logic              clearing,
  output logic [addr_w-1:0] clear_addr
);

  state_t state;

  // ready only rises on the edge that retires the last row, so the bank is
  // never visible to commands while any row still holds stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= STATE_CLEAR;
      clear_addr <= '0;
      ready      <= 1'b0;
    end else begin
      case (state)
        STATE_CLEAR: begin
          if (clear_addr == addr_w'(depth - 1)) begin
            state      <= STATE_READY;
            clear_addr <= '0;
            ready      <= 1'b1;
          end else begin
            clear_addr <= clear_addr + addr_w'(1);
          end
        end
        STATE_READY: begin
          if (clear) begin
            state      <= STATE_CLEAR;
            clear_addr <= '0;
            ready      <= 1'b0;
          end
        end
        default: begin
          state      <= STATE_CLEAR;
          clear_addr <= '0;
          ready      <= 1'b0;
        end
      endcase
    end
  end

  assign clearing = (state == STATE_CLEAR);

endmodule

// File: rtl/weight_bank.sv
// Per-layer weight store with row read, row write and saturating gradient
// update each cycle, plus range checking and a hardware clear sweep.
module weight_bank
  import gdo::*;
#(
  parameter int data_size  = 16,
  parameter int size       = 3,
  parameter int row_count  = 3,
  parameter int layer_size = 5,
  parameter int lr_shift   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  output logic                      ready,
  input  logic                      write_en,
  input  logic [31:0]               write_layer_index,
  input  logic [31:0]               write_row_index,
  input  logic [data_size*size-1:0] write_data,
  input  logic                      update_en,
  input  logic [31:0]               layer_index,
  input  logic [31:0]               row_index,
  input  logic [data_size*size-1:0] dc_dw,
  input  logic                      read_en,
  input  logic [31:0]               w_layer_index,
  input  logic [31:0]               w_row_index,
  output logic [data_size*size-1:0] w,
  output logic                      w_valid,
  output logic                      error
);

  localparam int depth  = layer_size * row_count;
  localparam int addr_w = (depth > 1) ? $clog2(depth) : 1;
  localparam int row_w  = data_size * size;

  logic [row_w-1:0]  mem [depth];
  logic              clearing;
  logic [addr_w-1:0] clear_addr;

  logic              wr_in_range, upd_in_range, rd_in_range;
  logic              wr_ok, upd_ok, rd_ok, bad_cmd, upd_blocked;
  logic [addr_w-1:0] wr_addr, upd_addr, rd_addr;
  logic [row_w-1:0]  upd_row;

  // Element 0 sits in the most-significant slice of every row bus.
  function automatic logic [row_w-1:0] apply_update(input logic [row_w-1:0] old_row,
                                                    input logic [row_w-1:0] grad_row);
    logic [row_w-1:0]            result;
    logic signed [data_size-1:0] old_e;
    logic signed [data_size-1:0] grad_e;
    result = '0;
    for (int i = 0; i < size; i++) begin
      old_e  = old_row[(size-1-i)*data_size +: data_size];
      grad_e = $signed(grad_row[(size-1-i)*data_size +: data_size]) >>> lr_shift;
      result[(size-1-i)*data_size +: data_size] =
        data_size'(gdo_sat_sub(64'(old_e), 64'(grad_e), data_size));
    end
    return result;
  endfunction

  weight_bank_clear_fsm #(
    .depth (depth),
    .addr_w(addr_w)
  ) u_clear_fsm (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .ready     (ready),
    .clearing  (clearing),
    .clear_addr(clear_addr)
  );

  assign wr_in_range  = (write_layer_index < 32'(layer_size)) && (write_row_index < 32'(row_count));
  assign upd_in_range = (layer_index < 32'(layer_size)) && (row_index < 32'(row_count));
  assign rd_in_range  = (w_layer_index < 32'(layer_size)) && (w_row_index < 32'(row_count));

  assign wr_ok  = ready && write_en && wr_in_range;
  assign upd_ok = ready && update_en && upd_in_range;
  assign rd_ok  = ready && read_en && rd_in_range;

  assign bad_cmd = ready && ((write_en && !wr_in_range) ||
                             (update_en && !upd_in_range) ||
                             (read_en && !rd_in_range));

  assign wr_addr  = addr_w'(write_layer_index * 32'(row_count) + write_row_index);
  assign upd_addr = addr_w'(layer_index * 32'(row_count) + row_index);
  assign rd_addr  = addr_w'(w_layer_index * 32'(row_count) + w_row_index);

  assign upd_row     = apply_update(mem[upd_addr], dc_dw);
  assign upd_blocked = wr_ok && (wr_addr == upd_addr);

  // Write is issued last so it overrides a same-row update; the read register
  // sees the pre-edge contents, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clearing) begin
        mem[clear_addr] <= '0;
      end else begin
        if (upd_ok && !upd_blocked) begin
          mem[upd_addr] <= upd_row;
        end
        if (wr_ok) begin
          mem[wr_addr] <= write_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w       <= '0;
      w_valid <= 1'b0;
      error   <= 1'b0;
    end else begin
      w       <= rd_ok ? mem[rd_addr] : '0;
      w_valid <= rd_ok;
      if (bad_cmd) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_weight_bank.sv
// Randomised bench for weight_bank checked every cycle against a row-array
// model of the bank, plus literal expectations from hand-worked cases.
module tb_weight_bank;

  localparam int DS    = 16;
  localparam int SZ    = 3;
  localparam int RC    = 3;
  localparam int LS    = 5;
  localparam int LR    = 2;
  localparam int DEPTH = LS * RC;
  localparam int RW    = DS * SZ;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          ready;
  logic          write_en = 1'b0;
  logic [31:0]   write_layer_index = '0;
  logic [31:0]   write_row_index = '0;
  logic [RW-1:0] write_data = '0;
  logic          update_en = 1'b0;
  logic [31:0]   layer_index = '0;
  logic [31:0]   row_index = '0;
  logic [RW-1:0] dc_dw = '0;
  logic          read_en = 1'b0;
  logic [31:0]   w_layer_index = '0;
  logic [31:0]   w_row_index = '0;
  logic [RW-1:0] w;
  logic          w_valid;
  logic          error;

  int checks = 0;
  int failures = 0;

  weight_bank #(
    .data_size (DS),
    .size      (SZ),
    .row_count (RC),
    .layer_size(LS),
    .lr_shift  (LR)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .clear            (clear),
    .ready            (ready),
    .write_en         (write_en),
    .write_layer_index(write_layer_index),
    .write_row_index  (write_row_index),
    .write_data       (write_data),
    .update_en        (update_en),
    .layer_index      (layer_index),
    .row_index        (row_index),
    .dc_dw            (dc_dw),
    .read_en          (read_en),
    .w_layer_index    (w_layer_index),
    .w_row_index      (w_row_index),
    .w                (w),
    .w_valid          (w_valid),
    .error            (error)
  );

  always #5 clk = ~clk;

  // Behavioural model: an array of integer weights, a sweep countdown and
  // the expected registered outputs after each edge.
  int   mem_m [DEPTH][SZ];
  bit   model_on = 1'b0;
  bit   m_ready = 1'b0;
  bit   m_err = 1'b0;
  int   sweep = 0;
  logic [RW-1:0] e_w = '0;
  bit   e_v = 1'b0;

  function automatic int elem(input logic [RW-1:0] bus, input int i);
    logic signed [DS-1:0] e;
    e = bus[(SZ-1-i)*DS +: DS];
    return int'(e);
  endfunction

  function automatic logic [RW-1:0] pack_row(input int a);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < SZ; i++) r[(SZ-1-i)*DS +: DS] = DS'(mem_m[a][i]);
    return r;
  endfunction

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic bit in_range(input logic [31:0] l, input logic [31:0] r);
    return (l < LS) && (r < RC);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      model_on = 1'b1;
      sweep = 0;
      m_ready = 1'b0;
      m_err = 1'b0;
      e_w = '0;
      e_v = 1'b0;
    end else if (!m_ready) begin
      e_w = '0;
      e_v = 1'b0;
      sweep++;
      if (sweep == DEPTH) begin
        m_ready = 1'b1;
        for (int a = 0; a < DEPTH; a++)
          for (int i = 0; i < SZ; i++) mem_m[a][i] = 0;
      end
    end else begin
      bit rd_ok, wr_ok, up_ok;
      int wa, ua, ra;
      rd_ok = read_en && in_range(w_layer_index, w_row_index);
      wr_ok = write_en && in_range(write_layer_index, write_row_index);
      up_ok = update_en && in_range(layer_index, row_index);
      ra = int'(w_layer_index) * RC + int'(w_row_index);
      wa = int'(write_layer_index) * RC + int'(write_row_index);
      ua = int'(layer_index) * RC + int'(row_index);
      e_v = rd_ok;
      e_w = rd_ok ? pack_row(ra) : '0;
      if ((read_en && !rd_ok) || (write_en && !wr_ok) || (update_en && !up_ok)) m_err = 1'b1;
      if (up_ok && !(wr_ok && wa == ua))
        for (int i = 0; i < SZ; i++) mem_m[ua][i] = sat(mem_m[ua][i] - (elem(dc_dw, i) >>> LR));
      if (wr_ok)
        for (int i = 0; i < SZ; i++) mem_m[wa][i] = elem(write_data, i);
      if (clear) begin
        m_ready = 1'b0;
        sweep = 0;
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      check_output("model_ready", 64'(ready), 64'(m_ready));
      check_output("model_error", 64'(error), 64'(m_err));
      check_output("model_w_valid", 64'(w_valid), 64'(e_v));
      check_output("model_w", 64'(w), 64'(e_w));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear = 1'b0;
    write_en = 1'b0;
    update_en = 1'b0;
    read_en = 1'b0;
  endtask

  task automatic apply_stimulus(input bit we, input logic [31:0] wl, input logic [31:0] wr,
                                input logic [RW-1:0] wd, input bit ue, input logic [31:0] ul,
                                input logic [31:0] ur, input logic [RW-1:0] ud, input bit re,
                                input logic [31:0] rl, input logic [31:0] rr, input bit clr);
    write_en = we; write_layer_index = wl; write_row_index = wr; write_data = wd;
    update_en = ue; layer_index = ul; row_index = ur; dc_dw = ud;
    read_en = re; w_layer_index = rl; w_row_index = rr; clear = clr;
    step();
    idle_inputs();
  endtask

  task automatic read_row(input int l, input int r, output logic [RW-1:0] data);
    apply_stimulus(0, 0, 0, '0, 0, 0, 0, '0, 1, l, r, 0);
    data = w;
  endtask

  task automatic reset_and_sweep();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check_output("reset_w", 64'(w), 64'd0);
    check_output("reset_w_valid", 64'(w_valid), 64'd0);
    check_output("reset_ready", 64'(ready), 64'd0);
    check_output("reset_error", 64'(error), 64'd0);
    reset = 1'b0;
    check_output("sweep_ready_low", 64'(ready), 64'd0);
    for (int i = 1; i < DEPTH; i++) begin
      step();
      check_output("sweep_ready_low", 64'(ready), 64'd0);
    end
    step();
    check_output("sweep_ready_high", 64'(ready), 64'd1);
  endtask

  task automatic read_all_zero();
    logic [RW-1:0] d;
    for (int l = 0; l < LS; l++)
      for (int r = 0; r < RC; r++) begin
        read_row(l, r, d);
        check_output("zero_row", 64'(d), 64'd0);
        check_output("zero_row_valid", 64'(w_valid), 64'd1);
      end
  endtask

  function automatic logic [31:0] pick_idx(input int hot_max, input int lim, input bit allow_bad);
    if (allow_bad && $urandom_range(0, 15) == 0) return 32'(lim + int'($urandom_range(0, 1000)));
    return 32'($urandom_range(0, hot_max));
  endfunction

  task automatic random_phase(input int n, input bit allow_bad);
    logic [63:0] t1, t2;
    for (int k = 0; k < n; k++) begin
      t1 = {$urandom(), $urandom()};
      t2 = {$urandom(), $urandom()};
      apply_stimulus($urandom_range(0, 1) == 1, pick_idx(1, LS, allow_bad), pick_idx(2, RC, allow_bad),
                     t1[RW-1:0], $urandom_range(0, 1) == 1, pick_idx(1, LS, allow_bad),
                     pick_idx(2, RC, allow_bad), t2[RW-1:0], $urandom_range(0, 3) != 0,
                     pick_idx(LS - 1, LS, allow_bad), pick_idx(RC - 1, RC, allow_bad),
                     allow_bad && ($urandom_range(0, 63) == 0));
      if (!ready) begin
        for (int s = 0; s < DEPTH; s++) step();
      end
    end
  endtask

  initial begin
    logic [RW-1:0] d;
    reset_and_sweep();
    read_all_zero();

    apply_stimulus(1, 2, 1, 48'h0010_FFF0_1234, 0, 0, 0, '0, 0, 0, 0, 0);
    read_row(2, 1, d);
    check_output("write_read", 64'(d), 64'h0000_0010_FFF0_1234);

    apply_stimulus(1, 1, 0, 48'h0100_8002_7FF0, 0, 0, 0, '0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, '0, 1, 1, 0, 48'h0040_0040_FF80, 0, 0, 0, 0);
    read_row(1, 0, d);
    check_output("sat_update", 64'(d), 64'h0000_00F0_8000_7FFF);

    apply_stimulus(1, 0, 2, 48'h0007_0008_0009, 0, 0, 0, '0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 2, 48'h0005_0005_0005, 1, 0, 2, 48'h0100_0100_0100, 1, 0, 2, 0);
    check_output("collide_old", 64'(w), 64'h0000_0007_0008_0009);
    read_row(0, 2, d);
    check_output("collide_write_wins", 64'(d), 64'h0000_0005_0005_0005);

    for (int k = 0; k < 4; k++)
      apply_stimulus(0, 0, 0, '0, 1, 0, 2, 48'hFFFC_0004_0000, 0, 0, 0, 0);
    read_row(0, 2, d);
    check_output("accumulate", 64'(d), 64'h0000_0009_0001_0005);

    random_phase(300, 1'b0);
    check_output("error_clean", 64'(error), 64'd0);

    apply_stimulus(1, 5, 0, 48'hAAAA_AAAA_AAAA, 0, 0, 0, '0, 0, 0, 0, 0);
    check_output("error_set", 64'(error), 64'd1);
    apply_stimulus(1, 4, 2, 48'h1111_2222_3333, 0, 0, 0, '0, 0, 0, 0, 0);
    read_row(4, 2, d);
    check_output("after_error_write", 64'(d), 64'h0000_1111_2222_3333);
    random_phase(300, 1'b1);
    check_output("error_sticky", 64'(error), 64'd1);

    apply_stimulus(1, 3, 1, 48'h0BAD_F00D_CAFE, 0, 0, 0, '0, 0, 0, 0, 1);
    check_output("clear_ready_drop", 64'(ready), 64'd0);
    for (int i = 1; i < 7; i++) step();
    reset_and_sweep();
    read_all_zero();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
